// File: rtl/digit_column_scanner_pkg.sv
// rtl/digit_column_scanner_pkg.sv - types and constants shared by the scanner and the 7-seg decoder
package digit_column_scanner_pkg;

    localparam int SEG_W      = 7;
    localparam int CHAR_WIDTH = 21;
    localparam int NUM_PAGES  = 4;

    typedef logic [SEG_W-1:0] Segments;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/digit_column_scanner.sv
// rtl/digit_column_scanner.sv - walks page/digit/column through the 7-seg decoder into a byte stream
module digit_column_scanner
    import digit_column_scanner_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int DISPLAY_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_DIGITS*SEG_W-1:0] digits_in,
    output logic [SEG_W-1:0]            seg_to_dec,
    output logic [4:0]                  index_x,
    output logic [1:0]                  index_y,
    input  logic [7:0]                  pixels_column,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_first,
    output logic                        out_last,
    output logic [1:0]                  out_page,
    output logic                        busy,
    output logic                        done
);

    localparam int COL_W      = $clog2(CHAR_WIDTH);
    localparam int PAGE_W     = $clog2(NUM_PAGES);
    localparam int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PAD_W      = $clog2(DISPLAY_WIDTH);
    localparam int DIGIT_COLS = NUM_DIGITS * CHAR_WIDTH;
    localparam bit HAS_PAD    = (DIGIT_COLS < DISPLAY_WIDTH);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(CHAR_WIDTH - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [PAD_W-1:0]  PAD_FIRST = PAD_W'(DIGIT_COLS);
    localparam logic [PAD_W-1:0]  PAD_LAST  = PAD_W'(DISPLAY_WIDTH - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 1);

    state_t                              r_state;
    state_t                              w_state_nx;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]    r_snap;
    logic [PAGE_W-1:0]                   r_page;
    logic [DIG_W-1:0]                    r_digit;
    logic [COL_W-1:0]                    r_col;
    logic [PAD_W-1:0]                    r_pad;
    logic                                r_in_pad;
    logic                                r_armed;
    logic [7:0]                          r_data;
    logic                                r_valid;
    logic                                r_first;
    logic                                r_last;
    logic [1:0]                          r_opage;
    logic                                r_done;

    logic w_accept;
    logic w_load;
    logic w_fin;
    logic w_pos_last;
    logic w_at_end;
    logic w_col0;

    assign w_pos_last = HAS_PAD ? (r_in_pad && (r_pad == PAD_LAST))
                                : (!r_in_pad && (r_digit == DIG_LAST) && (r_col == COL_LAST));
    assign w_at_end   = (r_page == PAGE_LAST) && w_pos_last;
    assign w_col0     = !r_in_pad && (r_digit == '0) && (r_col == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // The cycle right after done still reads as IDLE but must not start a new frame.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_load     = 1'b0;
        w_fin      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !r_done) begin
                    w_accept   = 1'b1;
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (r_armed && (!r_valid || out_ready)) begin
                    w_load = 1'b1;
                    if (w_at_end) begin
                        w_state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (r_valid && out_ready) begin
                    w_fin      = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap   <= '0;
            r_page   <= '0;
            r_digit  <= '0;
            r_col    <= '0;
            r_pad    <= '0;
            r_in_pad <= 1'b0;
            r_armed  <= 1'b0;
            r_data   <= 8'h00;
            r_valid  <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_opage  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_accept) begin
                r_snap   <= digits_in;
                r_page   <= '0;
                r_digit  <= '0;
                r_col    <= '0;
                r_pad    <= '0;
                r_in_pad <= 1'b0;
                r_armed  <= 1'b0;
            end else if (r_state == RUN && !r_armed) begin
                // One settle cycle so the decoder sees the fresh snapshot before the first load.
                r_armed <= 1'b1;
            end
            if (w_load) begin
                r_data  <= r_in_pad ? 8'h00 : pixels_column;
                r_valid <= 1'b1;
                r_first <= w_col0;
                r_last  <= w_at_end;
                r_opage <= r_page;
                if (!w_at_end) begin
                    if (r_in_pad) begin
                        if (r_pad == PAD_LAST) begin
                            r_in_pad <= 1'b0;
                            r_pad    <= '0;
                            r_page   <= r_page + PAGE_W'(1);
                        end else begin
                            r_pad <= r_pad + PAD_W'(1);
                        end
                    end else if (r_col == COL_LAST) begin
                        r_col <= '0;
                        if (r_digit == DIG_LAST) begin
                            r_digit <= '0;
                            if (HAS_PAD) begin
                                r_in_pad <= 1'b1;
                                r_pad    <= PAD_FIRST;
                            end else begin
                                r_page <= r_page + PAGE_W'(1);
                            end
                        end else begin
                            r_digit <= r_digit + DIG_W'(1);
                        end
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
            end
            if (w_fin) begin
                r_valid <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign seg_to_dec = ((r_state != IDLE) && !r_in_pad) ? r_snap[r_digit] : '0;
    assign index_x    = r_col;
    assign index_y    = r_page;
    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign out_first  = r_first;
    assign out_last   = r_last;
    assign out_page   = r_opage;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;

endmodule

// File: tb/tb_digit_column_scanner.sv
// tb/tb_digit_column_scanner.sv - randomized frame checks against a frame-level reference model
module tb_digit_column_scanner;
    import digit_column_scanner_pkg::*;

    localparam int ND    = 6;
    localparam int DW    = 128;
    localparam int NB    = NUM_PAGES * DW;
    localparam int DCOLS = ND * CHAR_WIDTH;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [ND*SEG_W-1:0]   digits_in = '0;
    logic [SEG_W-1:0]      seg_to_dec;
    logic [4:0]            index_x;
    logic [1:0]            index_y;
    logic [7:0]            pixels_column;
    logic [7:0]            out_data;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic                  out_first;
    logic                  out_last;
    logic [1:0]            out_page;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int failures = 0;
    bit dark = 1'b1;
    bit rnd_ready = 1'b0;

    logic [ND-1:0][SEG_W-1:0] m_snap;
    bit        m_idle = 1'b1;
    bit        m_done = 1'b0;
    int        hs_k = 0;
    int        since = 0;
    int        first_cnt = 0;
    int        last_cnt = 0;
    logic [7:0] rx [NB];
    logic [6:0] fseg [NB];
    logic [4:0] fx [NB];

    digit_column_scanner #(.NUM_DIGITS(ND), .DISPLAY_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .digits_in(digits_in),
        .seg_to_dec(seg_to_dec), .index_x(index_x), .index_y(index_y),
        .pixels_column(pixels_column), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
        .out_page(out_page), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Stand-in decoder: a distinct byte per (segments, column, page); "dark" makes blank digits emit zero.
    function automatic logic [7:0] dec(input logic [6:0] seg, input int x, input int y, input bit dk);
        if (dk && seg == 7'd0) return 8'h00;
        return 8'((int'(seg) * 3 + x * 5 + y * 64 + 17) & 255);
    endfunction

    always_comb pixels_column = dec(seg_to_dec, int'(index_x), int'(index_y), dark);

    always @(posedge clk) begin
        #2;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [7:0] m_byte(input int k);
        int p;
        int col;
        p   = k / DW;
        col = k % DW;
        if (col >= DCOLS) return 8'h00;
        return dec(m_snap[col / CHAR_WIDTH], col % CHAR_WIDTH, p, dark);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit now_idle;
        bit now_done;
        bit acc;
        int fk;
        int p;
        int col;
        if (reset) begin
            m_idle = 1'b1;
            m_done = 1'b0;
            hs_k   = 0;
            since  = 0;
        end else begin
            now_idle = m_idle;
            now_done = m_done;
            chk("done", int'(done), int'(now_done));
            chk("busy", int'(busy), int'(!now_idle));
            m_done = 1'b0;
            if (!now_idle) begin
                since++;
                chk("valid", int'(out_valid), int'(since >= 3));
                if (out_valid) begin
                    chk("data", int'(out_data), int'(m_byte(hs_k)));
                    chk("first", int'(out_first), int'((hs_k % DW) == 0));
                    chk("last", int'(out_last), int'(hs_k == NB - 1));
                    chk("page", int'(out_page), hs_k / DW);
                end
                fk = hs_k + int'(out_valid);
                if (fk < NB) begin
                    p   = fk / DW;
                    col = fk % DW;
                    chk("seg_to_dec", int'(seg_to_dec),
                        (col < DCOLS) ? int'(m_snap[col / CHAR_WIDTH]) : 0);
                    chk("index_y", int'(index_y), p);
                    if (col < DCOLS) chk("index_x", int'(index_x), col % CHAR_WIDTH);
                    fseg[fk] = seg_to_dec;
                    fx[fk]   = index_x;
                end
                if (out_valid && out_ready) begin
                    rx[hs_k] = out_data;
                    if (out_first) first_cnt++;
                    if (out_last) last_cnt++;
                    hs_k++;
                    if (hs_k == NB) begin
                        m_idle = 1'b1;
                        m_done = 1'b1;
                    end
                end
            end else begin
                chk("idle_valid", int'(out_valid), 0);
            end
            acc = now_idle && start && !now_done;
            if (acc) begin
                m_idle = 1'b0;
                m_snap = digits_in;
                hs_k   = 0;
                since  = 0;
            end
        end
    end

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("frame_done_seen", int'(seen), 1);
    endtask

    task automatic clear_rx();
        for (int i = 0; i < NB; i++) rx[i] = 8'hEE;
        first_cnt = 0;
        last_cnt  = 0;
    endtask

    task automatic run_frame(input logic [ND*SEG_W-1:0] dig);
        clear_rx();
        digits_in = dig;
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done();
    endtask

    function automatic logic [ND*SEG_W-1:0] rand_digits();
        logic [ND*SEG_W-1:0] v;
        for (int i = 0; i < ND; i++) v[i*SEG_W +: SEG_W] = 7'($urandom_range(0, 127));
        return v;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_data"}, int'(out_data), 0);
        chk({tag, "_first"}, int'(out_first), 0);
        chk({tag, "_last"}, int'(out_last), 0);
        chk({tag, "_page"}, int'(out_page), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_seg"}, int'(seg_to_dec), 0);
        chk({tag, "_ix"}, int'(index_x), 0);
        chk({tag, "_iy"}, int'(index_y), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        bit found;
        logic [ND*SEG_W-1:0] dig_a;
        logic [ND*SEG_W-1:0] fetch_dig;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(posedge clk); #2;
        reset = 1'b0;

        // Blank frame, no stalls, with explicit latency observation.
        dark = 1'b1;
        rnd_ready = 1'b0;
        clear_rx();
        digits_in = '0;
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        chk("lat_busy_e", int'(busy), 1);
        chk("lat_valid_e", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_valid_e1", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_valid_e2", int'(out_valid), 1);
        chk("lat_first_e2", int'(out_first), 1);
        wait_done();
        nz = 0;
        for (int i = 0; i < NB; i++) if (rx[i] != 8'h00) nz++;
        chk("blank_nonzero_bytes", nz, 0);
        chk("blank_first_count", first_cnt, 4);
        chk("blank_last_count", last_cnt, 1);

        // Digit 0 = '8', rest blank.
        run_frame(42'h7F);
        chk("eight_b0", int'(rx[0]), 8'h8E);
        chk("eight_b130", int'(rx[130]), 8'hD8);
        chk("eight_b404", int'(rx[404]), 8'hB2);
        chk("eight_b21", int'(rx[21]), 0);
        chk("eight_b127", int'(rx[127]), 0);

        // Random digits, random backpressure, live decoder output on blanks.
        dark = 1'b0;
        rnd_ready = 1'b1;
        run_frame(rand_digits());
        chk("stall_bytes", hs_k, NB);
        chk("stall_first_count", first_cnt, 4);

        // Known digits 1..6 to pin the page-2 fetch order.
        rnd_ready = 1'b0;
        for (int i = 0; i < ND; i++) fetch_dig[i*SEG_W +: SEG_W] = 7'(i + 1);
        run_frame(fetch_dig);
        chk("fetch_p2_d0_seg", int'(fseg[256]), 1);
        chk("fetch_p2_d1_seg", int'(fseg[277]), 2);
        chk("fetch_p2_d1_x", int'(fx[277]), 0);
        chk("fetch_p2_d2_seg", int'(fseg[318]), 3);
        chk("fetch_p2_d2_x", int'(fx[318]), 20);
        chk("fetch_p2_pad_seg", int'(fseg[382]), 0);
        chk("fetch_p2_pad_byte", int'(rx[383]), 0);

        // start and new digits mid-frame, start again in the done cycle.
        rnd_ready = 1'b1;
        clear_rx();
        dig_a = rand_digits();
        digits_in = dig_a;
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        digits_in = ~dig_a;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_last) found = 1'b1;
        end
        chk("ignore_last_seen", int'(found), 1);
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("ignore_done_start", int'(busy), 0);
        chk("ignore_bytes", hs_k, NB);

        // Reset after 100 bytes, then a clean frame.
        rnd_ready = 1'b0;
        clear_rx();
        digits_in = rand_digits();
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (hs_k >= 100) found = 1'b1;
        end
        chk("midreset_progress", int'(found), 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk); #2;
        reset = 1'b0;
        run_frame(rand_digits());
        chk("after_reset_first_count", first_cnt, 4);
        chk("after_reset_bytes", hs_k, NB);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
